block_cost_select: RTL

Downstream stage of the block matcher. Every cycle `blks_valid` is high, it takes a binary reference block and a binary search-window candidate and computes their Hamming cost (XOR plus popcount). The cost computation is a 3-stage pipeline. Over one search it tracks the minimum-cost candidate and the runner-up cost. When the search ends it emits one result record per reference block.

---
 rtl/block_match_pkg.sv | 30 +++
 rtl/block_popcount_row.sv | 49 ++++
 rtl/block_cost_select.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/block_match_pkg.sv
// rtl/block_match_pkg.sv - shared types and width helpers for the block matcher
package block_match_pkg;

  // Ceiling log2; used to size the per-row popcounts and the total cost.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
  } coord_t;

  typedef struct packed {
    logic        valid;
    logic        first;
    logic        last;
    coord_t      coords;
    logic [15:0] index;
  } cand_tag_t;

  typedef enum logic {
    st_armed = 1'b0,
    st_accum = 1'b1
  } search_state_t;

endpackage

// File: rtl/block_popcount_row.sv
// rtl/block_popcount_row.sv - two-stage row popcount and sum with fixed 2-cycle latency
module block_popcount_row
  import block_match_pkg::*;
#(
  parameter int block_size = 16,
  parameter int cost_w     = 9
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [block_size*block_size-1:0] xor_word,
  output logic [cost_w-1:0]                cost
);

  localparam int row_w = clog2(block_size + 1);

  logic [row_w-1:0]  row_cnt_d [block_size];
  logic [row_w-1:0]  row_cnt_q [block_size];
  logic [cost_w-1:0] sum_d;

  // Count the set bits of each row independently.
  always_comb begin
    for (int r = 0; r < block_size; r++) begin
      row_cnt_d[r] = '0;
      for (int c = 0; c < block_size; c++) begin
        row_cnt_d[r] = row_cnt_d[r] + row_w'(xor_word[r*block_size + c]);
      end
    end
  end

  // Add the registered row counts; the maximum fits cost_w, so no saturation.
  always_comb begin
    sum_d = '0;
    for (int r = 0; r < block_size; r++) begin
      sum_d = sum_d + cost_w'(row_cnt_q[r]);
    end
  end

  // Row-count register followed by the total-cost register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < block_size; r++) row_cnt_q[r] <= '0;
      cost <= '0;
    end else begin
      for (int r = 0; r < block_size; r++) row_cnt_q[r] <= row_cnt_d[r];
      cost <= sum_d;
    end
  end

endmodule

// File: rtl/block_cost_select.sv
// rtl/block_cost_select.sv - Hamming cost pipeline with per-search best/runner-up selection
module block_cost_select
  import block_match_pkg::*;
#(
  parameter int block_size = 16,
  parameter int cost_w     = 9
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [block_size*block_size-1:0] blk_block,
  input  logic [block_size*block_size-1:0] srch_block,
  input  logic [15:0]                      coords_in,
  input  logic [15:0]                      blk_index_in,
  input  logic                             blks_valid,
  input  logic                             match_done,
  output logic                             result_valid,
  output logic [15:0]                      best_coords,
  output logic [cost_w-1:0]                best_cost,
  output logic [cost_w-1:0]                second_cost,
  output logic [15:0]                      result_blk_index
);

  localparam logic [cost_w-1:0] cost_max = '1;

  search_state_t                    state_q, state_d;
  logic                             first_tag, last_tag;
  logic                             match_done_q;
  logic [block_size*block_size-1:0] xor_q;
  cand_tag_t                        tag_s0, tag_s1, tag_s2;
  logic [cost_w-1:0]                cost_s2;

  logic [cost_w-1:0] run_cost, run_second, nxt_cost, nxt_second;
  coord_t            run_coords, nxt_coords;
  logic [15:0]       run_index, nxt_index;

  // Search state register: armed means the next valid candidate starts a search.
  always_ff @(posedge clk) begin
    if (reset) state_q <= st_armed;
    else       state_q <= state_d;
  end

  // A last candidate re-arms; any other valid candidate moves into accumulation.
  always_comb begin
    state_d = state_q;
    if (blks_valid) state_d = last_tag ? st_armed : st_accum;
  end

  // Tags attached at capture; a done edge without a candidate tags nothing.
  always_comb begin
    first_tag = (state_q == st_armed);
    last_tag  = blks_valid & match_done & ~match_done_q;
  end

  // S0: capture the XOR word and the candidate tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_done_q <= 1'b1;
      tag_s0       <= '0;
      xor_q        <= '0;
    end else begin
      match_done_q  <= match_done;
      tag_s0.valid  <= blks_valid;
      tag_s0.first  <= first_tag;
      tag_s0.last   <= last_tag;
      tag_s0.coords <= coord_t'(coords_in);
      tag_s0.index  <= blk_index_in;
      xor_q         <= blk_block ^ srch_block;
    end
  end

  // Tags travel alongside the two popcount stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_s1 <= '0;
      tag_s2 <= '0;
    end else begin
      tag_s1 <= tag_s0;
      tag_s2 <= tag_s1;
    end
  end

  block_popcount_row #(
    .block_size(block_size),
    .cost_w    (cost_w)
  ) u_popcount (
    .clk     (clk),
    .reset   (reset),
    .xor_word(xor_q),
    .cost    (cost_s2)
  );

  // S3 selection; strict compares keep the earliest candidate on ties.
  always_comb begin
    nxt_cost   = run_cost;
    nxt_second = run_second;
    nxt_coords = run_coords;
    nxt_index  = run_index;
    if (tag_s2.valid) begin
      if (tag_s2.first) begin
        nxt_cost   = cost_s2;
        nxt_coords = tag_s2.coords;
        nxt_second = cost_max;
        nxt_index  = tag_s2.index;
      end else if (cost_s2 < run_cost) begin
        nxt_second = run_cost;
        nxt_cost   = cost_s2;
        nxt_coords = tag_s2.coords;
      end else if (cost_s2 < run_second) begin
        nxt_second = cost_s2;
      end
    end
  end

  // Running state update and publication of the result on the last candidate.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cost         <= '0;
      run_second       <= '0;
      run_coords       <= '0;
      run_index        <= '0;
      result_valid     <= 1'b0;
      best_coords      <= '0;
      best_cost        <= '0;
      second_cost      <= '0;
      result_blk_index <= '0;
    end else begin
      run_cost     <= nxt_cost;
      run_second   <= nxt_second;
      run_coords   <= nxt_coords;
      run_index    <= nxt_index;
      result_valid <= tag_s2.valid & tag_s2.last;
      if (tag_s2.valid & tag_s2.last) begin
        best_coords      <= nxt_coords;
        best_cost        <= nxt_cost;
        second_cost      <= nxt_second;
        result_blk_index <= nxt_index;
      end
    end
  end

endmodule
